display_scan_ctrl: RTL and testbench



---
 rtl/display_pkg.sv | 20 ++
 rtl/scan_prescaler.sv | 31 +++
 rtl/display_scan_ctrl.sv | 204 ++++++++++++++++++++
 tb/tb_display_scan_ctrl.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// Shared types and constants for the multiplexed 7-segment display scanner
// and the decoder it feeds.
package display_pkg;

  typedef enum logic [0:0] {
    S_BLANK = 1'b0,
    S_ON    = 1'b1
  } scan_state_t;

  typedef logic [3:0] nibble_t;

  localparam int MAX_DIGITS = 8;
  localparam logic [MAX_DIGITS-1:0] ANODE_OFF = 8'hFF;

  // A digit index is never narrower than one bit, even for tiny banks.
  function automatic int idx_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/scan_prescaler.sv
// Slot timer for the display scanner: counts 0..PRESCALE-1 and flags the
// last blank cycle and the last cycle of each digit slot.
module scan_prescaler #(
  parameter int PRESCALE     = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic clk,
  input  logic rst_n,
  output logic blank_end,
  output logic slot_end
);

  localparam int CNT_W = $clog2(PRESCALE);

  logic [CNT_W-1:0] cnt_r;

  assign blank_end = (cnt_r == CNT_W'(BLANK_CYCLES - 1));
  assign slot_end  = (cnt_r == CNT_W'(PRESCALE - 1));

  // Free-running slot counter, restarting at every slot boundary
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (slot_end) begin
      cnt_r <= {CNT_W{1'b0}};
    end else begin
      cnt_r <= cnt_r + CNT_W'(1);
    end
  end

endmodule

// File: rtl/display_scan_ctrl.sv
// Time-multiplexed scan controller for a common-anode 7-segment bank sharing
// one decoder. Optional build macro: LEADING_ZERO_BLANK_EN.
module display_scan_ctrl
  import display_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int PRESCALE     = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  output logic [3:0]              bcd_out,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_done,
  output logic                    pending
);

  localparam int IDX_W = idx_width(NUM_DIGITS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] AN_OFF = ANODE_OFF[NUM_DIGITS-1:0];

  scan_state_t               state_r, state_next_s;
  logic [IDX_W-1:0]          idx_r, idx_next_s;
  logic [4*NUM_DIGITS-1:0]   act_val_r, act_val_next_s, shd_val_r;
  logic [NUM_DIGITS-1:0]     act_en_r, act_en_next_s, shd_en_r;
  logic                      pending_r, pending_next_s;
  logic [NUM_DIGITS-1:0]     an_r, an_next_s, show_s;
  nibble_t                   bcd_r, bcd_next_s;
  logic                      frame_done_r;
  logic                      blank_end_s, slot_end_s, advance_s, wrap_s;

  function automatic nibble_t pick_nibble(input logic [4*NUM_DIGITS-1:0] val,
                                          input logic [IDX_W-1:0] i);
    nibble_t n;
    n = 4'h0;
    for (int d = 0; d < NUM_DIGITS; d++) begin
      if (i == IDX_W'(d)) begin
        n = val[4*d +: 4];
      end else begin
        n = n;
      end
    end
    return n;
  endfunction

  function automatic logic [NUM_DIGITS-1:0] anode_low(input logic [IDX_W-1:0] i);
    logic [NUM_DIGITS-1:0] a;
    a = AN_OFF;
    for (int d = 0; d < NUM_DIGITS; d++) begin
      if (i == IDX_W'(d)) begin
        a[d] = 1'b0;
      end else begin
        a[d] = 1'b1;
      end
    end
    return a;
  endfunction

`ifdef LEADING_ZERO_BLANK_EN
  // Bit d is set when digits d..NUM_DIGITS-1 are all zero; digit 0 always shows.
  function automatic logic [NUM_DIGITS-1:0] lead_zero_mask(input logic [4*NUM_DIGITS-1:0] val);
    logic [NUM_DIGITS-1:0] m;
    logic                  upper_zero;
    m          = {NUM_DIGITS{1'b0}};
    upper_zero = 1'b1;
    for (int d = NUM_DIGITS - 1; d >= 1; d--) begin
      upper_zero = upper_zero & (val[4*d +: 4] == 4'h0);
      m[d]       = upper_zero;
    end
    return m;
  endfunction

  assign show_s = act_en_next_s & ~lead_zero_mask(act_val_next_s);
`else
  assign show_s = act_en_next_s;
`endif

  scan_prescaler #(
    .PRESCALE     (PRESCALE),
    .BLANK_CYCLES (BLANK_CYCLES)
  ) u_prescaler (
    .clk       (clk),
    .rst_n     (rst_n),
    .blank_end (blank_end_s),
    .slot_end  (slot_end_s)
  );

  assign advance_s = (state_r == S_ON) && slot_end_s;
  assign wrap_s    = advance_s && (idx_r == LAST_IDX);

  // Scan FSM next state
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      S_BLANK: begin
        if (blank_end_s) state_next_s = S_ON;
        else             state_next_s = S_BLANK;
      end
      S_ON: begin
        if (slot_end_s) state_next_s = S_BLANK;
        else            state_next_s = S_ON;
      end
      default: state_next_s = S_BLANK;
    endcase
  end

  // Digit index: advances at each slot end, wraps after the last digit
  always_comb begin
    idx_next_s = idx_r;
    if (wrap_s) begin
      idx_next_s = {IDX_W{1'b0}};
    end else if (advance_s) begin
      idx_next_s = idx_r + IDX_W'(1);
    end else begin
      idx_next_s = idx_r;
    end
  end

  // Active value only changes at the frame wrap; a load in that very cycle bypasses the shadow
  always_comb begin
    act_val_next_s = act_val_r;
    act_en_next_s  = act_en_r;
    pending_next_s = pending_r;
    if (wrap_s) begin
      pending_next_s = 1'b0;
      if (load) begin
        act_val_next_s = value;
        act_en_next_s  = digit_en;
      end else if (pending_r) begin
        act_val_next_s = shd_val_r;
        act_en_next_s  = shd_en_r;
      end else begin
        act_val_next_s = act_val_r;
        act_en_next_s  = act_en_r;
      end
    end else if (load) begin
      pending_next_s = 1'b1;
    end else begin
      pending_next_s = pending_r;
    end
  end

  // Output next values: anodes follow the upcoming state, nibble changes as blanking starts
  always_comb begin
    an_next_s  = AN_OFF;
    bcd_next_s = bcd_r;
    if ((state_next_s == S_ON) && show_s[idx_next_s]) begin
      an_next_s = anode_low(idx_next_s);
    end else begin
      an_next_s = AN_OFF;
    end
    if (advance_s) begin
      bcd_next_s = pick_nibble(act_val_next_s, idx_next_s);
    end else begin
      bcd_next_s = bcd_r;
    end
  end

  // Scan state, index and display registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= S_BLANK;
      idx_r        <= {IDX_W{1'b0}};
      act_val_r    <= {(4*NUM_DIGITS){1'b0}};
      act_en_r     <= {NUM_DIGITS{1'b1}};
      pending_r    <= 1'b0;
      an_r         <= AN_OFF;
      bcd_r        <= 4'h0;
      frame_done_r <= 1'b0;
    end else begin
      state_r      <= state_next_s;
      idx_r        <= idx_next_s;
      act_val_r    <= act_val_next_s;
      act_en_r     <= act_en_next_s;
      pending_r    <= pending_next_s;
      an_r         <= an_next_s;
      bcd_r        <= bcd_next_s;
      frame_done_r <= wrap_s;
    end
  end

  // Shadow capture; the last load before the frame boundary wins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shd_val_r <= {(4*NUM_DIGITS){1'b0}};
      shd_en_r  <= {NUM_DIGITS{1'b1}};
    end else if (load) begin
      shd_val_r <= value;
      shd_en_r  <= digit_en;
    end else begin
      shd_val_r <= shd_val_r;
      shd_en_r  <= shd_en_r;
    end
  end

  assign an         = an_r;
  assign bcd_out    = bcd_r;
  assign frame_done = frame_done_r;
  assign pending    = pending_r;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Scoreboard bench for display_scan_ctrl: per-frame expectations are queued as
// stimulus is planned and a negedge monitor checks every output cycle.
module tb_display_scan_ctrl;

  localparam int ND    = 4;
  localparam int PS    = 8;
  localparam int BC    = 2;
  localparam int FRAME = ND * PS;

  logic        clk      = 1'b0;
  logic        rst_n    = 1'b0;
  logic        load     = 1'b0;
  logic [15:0] value    = 16'h0;
  logic [3:0]  digit_en = 4'h0;
  logic [3:0]  bcd_out;
  logic [3:0]  an;
  logic        frame_done;
  logic        pending;

  display_scan_ctrl #(
    .NUM_DIGITS   (ND),
    .PRESCALE     (PS),
    .BLANK_CYCLES (BC)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load),
    .value      (value),
    .digit_en   (digit_en),
    .bcd_out    (bcd_out),
    .an         (an),
    .frame_done (frame_done),
    .pending    (pending)
  );

  always #5 clk = ~clk;

  // What one frame should show, plus the position of its first load (-1: none).
  typedef struct {
    logic [15:0] val;
    logic [3:0]  en;
    int          first;
  } frame_rec_t;

  frame_rec_t  exp_q[$];
  int          checks   = 0;
  int          failures = 0;
  bit          run      = 1'b0;
  logic [15:0] cur_val;
  logic [3:0]  cur_en;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: expected display derived from slot arithmetic on the frame record
  frame_rec_t mon_rec;
  int         mon_cyc = 0;
  always @(negedge clk) begin
    int   p;
    int   slot;
    int   off;
    logic vis;
    logic [3:0] e_an;
    if (!run) begin
      mon_cyc = 0;
    end else begin
      p    = mon_cyc % FRAME;
      slot = p / PS;
      off  = p % PS;
      if (p == 0) begin
        chk("scoreboard_nonempty", 16'(exp_q.size() > 0), 16'd1);
        if (exp_q.size() > 0) mon_rec = exp_q.pop_front();
      end
      vis = mon_rec.en[slot];
`ifdef LEADING_ZERO_BLANK_EN
      if (slot != 0 && (mon_rec.val >> (4 * slot)) == 16'h0) vis = 1'b0;
`endif
      e_an = 4'hF;
      if (off >= BC && vis) e_an[slot] = 1'b0;
      chk("an", 16'(an), 16'(e_an));
      chk("bcd_out", 16'(bcd_out), (mon_rec.val >> (4 * slot)) & 16'h000F);
      chk("pending", 16'(pending), 16'(mon_rec.first >= 0 && p > mon_rec.first));
      chk("frame_done", 16'(frame_done), 16'(p == 0 && mon_cyc > 0));
      mon_cyc++;
    end
  end

  // Drive one frame (or its first ncyc cycles) with up to two loads; called at posedge+1 of the frame's first cycle.
  task automatic run_frame(input int nl,
                           input int p0, input logic [15:0] v0, input logic [3:0] e0,
                           input int p1, input logic [15:0] v1, input logic [3:0] e1,
                           input int ncyc);
    frame_rec_t r;
    r.val   = cur_val;
    r.en    = cur_en;
    r.first = -1;
    if (nl >= 1) r.first = p0;
    if (nl >= 2 && p1 < p0) r.first = p1;
    exp_q.push_back(r);
    for (int c = 0; c < ncyc; c++) begin
      load = 1'b0;
      if (nl >= 1 && c == p0) begin
        load = 1'b1; value = v0; digit_en = e0;
      end
      if (nl >= 2 && c == p1) begin
        load = 1'b1; value = v1; digit_en = e1;
      end
      @(posedge clk);
      #1;
    end
    load = 1'b0;
    if (nl == 1 || (nl == 2 && p0 > p1)) begin
      cur_val = v0; cur_en = e0;
    end else if (nl == 2) begin
      cur_val = v1; cur_en = e1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete within 200000 time units");
    $fatal(1, "timeout");
  end

  initial begin
    int          nl;
    int          p0;
    int          p1;
    logic [15:0] v0;
    logic [15:0] v1;
    logic [3:0]  e0;
    logic [3:0]  e1;

    cur_val = 16'h0000;
    cur_en  = 4'hF;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_an", 16'(an), 16'h000F);
    chk("reset_bcd", 16'(bcd_out), 16'h0000);
    chk("reset_pending", 16'(pending), 16'h0000);
    chk("reset_frame_done", 16'(frame_done), 16'h0000);
    rst_n = 1'b1;
    run   = 1'b1;

    run_frame(1, 31, 16'h1234, 4'hF,    0, 16'h0, 4'h0, FRAME); // load in wrap cycle
    run_frame(1, 10, 16'hABCD, 4'hF,    0, 16'h0, 4'h0, FRAME); // mid-frame at idx 1
    run_frame(2, 5,  16'h1111, 4'hF,   20, 16'h2222, 4'hF, FRAME);
    run_frame(1, 31, 16'h5A5A, 4'b0101, 0, 16'h0, 4'h0, FRAME);
    run_frame(0, 0,  16'h0, 4'h0,       0, 16'h0, 4'h0, FRAME);

    for (int f = 0; f < 20; f++) begin
      nl = $urandom_range(0, 2);
      p0 = $urandom_range(0, FRAME - 1);
      if ($urandom_range(0, 3) == 0) p0 = FRAME - 1;
      p1 = (p0 + $urandom_range(1, FRAME - 1)) % FRAME;
      v0 = 16'($urandom);
      v1 = 16'($urandom);
      e0 = 4'($urandom);
      e1 = 4'($urandom);
      run_frame(nl, p0, v0, e0, p1, v1, e1, FRAME);
    end

    // Reset asserted mid S_ON of digit 2 with a load pending
    run_frame(1, 31, 16'h8765, 4'hF, 0, 16'h0, 4'h0, FRAME);
    run_frame(1, 5,  16'h1357, 4'hF, 0, 16'h0, 4'h0, 2 * PS + 3);
    run = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_an", 16'(an), 16'h000F);
    chk("async_reset_bcd", 16'(bcd_out), 16'h0000);
    chk("async_reset_pending", 16'(pending), 16'h0000);
    exp_q.delete();
    cur_val = 16'h0000;
    cur_en  = 4'hF;
    @(posedge clk);
    #1;
    chk("held_reset_an", 16'(an), 16'h000F);
    chk("held_reset_frame_done", 16'(frame_done), 16'h0000);
    rst_n = 1'b1;
    run   = 1'b1;

    run_frame(1, 31, 16'h0042, 4'hF, 0, 16'h0, 4'h0, FRAME);
    run_frame(0, 0,  16'h0, 4'h0,    0, 16'h0, 4'h0, FRAME);
    run_frame(0, 0,  16'h0, 4'h0,    0, 16'h0, 4'h0, FRAME);
    run = 1'b0;
    @(posedge clk);
    #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
